// File: rtl/regfile_sequencer.sv
// regfile_sequencer: issues one three-address instruction at a time onto a
// 16x16 register file (two combinational read ports, one write port).
// Each instruction runs READ then WRITE, or a 16-cycle CLEAR sweep.
// It also keeps the zero and carry flags.
module regfile_sequencer (
  input  logic        C,
  input  logic        RST,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [3:0]  OP,
  input  logic [3:0]  DST,
  input  logic [3:0]  SRCA,
  input  logic [3:0]  SRCB,
  input  logic [15:0] IMM,
  output logic [3:0]  A_SEL,
  output logic [3:0]  B_SEL,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic [15:0] D,
  output logic [3:0]  DEST_SEL,
  output logic        LOAD_EN,
  output logic        DONE,
  output logic        Z,
  output logic        CY
);

  localparam int DATA_W = 16;

  localparam logic [3:0] OP_MOV = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_NOT = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;
  localparam logic [3:0] OP_LDI = 4'd10;
  localparam logic [3:0] OP_CLR = 4'd11;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_CLEAR} state_t;

  state_t              state_q, state_d;
  logic [3:0]          op_p0, dst_p0, srca_p0, srcb_p0;
  logic [DATA_W-1:0]   imm_p0;
  logic [DATA_W-1:0]   opa_p1, opb_p1;
  logic [3:0]          clr_cnt;
  logic                z_q, cy_q;
  logic [DATA_W:0]     alu_res;

  // Result in [15:0]; carry/borrow in bit 16 (only meaningful for ADD/SUB).
  function automatic logic [DATA_W:0] alu_calc(input logic [3:0] op,
                                               input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b,
                                               input logic [DATA_W-1:0] imm);
    logic [DATA_W:0] r;
    r = '0;
    case (op)
      OP_MOV:  r = {1'b0, a};
      OP_ADD:  r = {1'b0, a} + {1'b0, b};
      OP_SUB:  r = {(a < b), a - b};
      OP_AND:  r = {1'b0, a & b};
      OP_OR:   r = {1'b0, a | b};
      OP_XOR:  r = {1'b0, a ^ b};
      OP_NOT:  r = {1'b0, ~a};
      OP_SHL:  r = {1'b0, a << b[3:0]};
      OP_SHR:  r = {1'b0, a >> b[3:0]};
      OP_LDI:  r = {1'b0, imm};
      default: r = '0;
    endcase
    return r;
  endfunction

  // Opcodes that commit a result; NOP and reserved codes fall outside.
  function automatic logic is_write_op(input logic [3:0] op);
    return (op >= OP_MOV) && (op <= OP_LDI);
  endfunction

  assign alu_res = alu_calc(op_p0, opa_p1, opb_p1, imm_p0);
  assign Z       = z_q;
  assign CY      = cy_q;

  // State register.
  always_ff @(posedge C) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state and register-file port drive; reset masks every output.
  always_comb begin
    state_d  = state_q;
    IN_READY = 1'b0;
    A_SEL    = '0;
    B_SEL    = '0;
    D        = '0;
    DEST_SEL = '0;
    LOAD_EN  = 1'b0;
    DONE     = 1'b0;
    case (state_q)
      S_IDLE: begin
        IN_READY = 1'b1;
        if (IN_VALID) state_d = (OP == OP_CLR) ? S_CLEAR : S_READ;
      end
      S_READ: begin
        A_SEL   = srca_p0;
        B_SEL   = srcb_p0;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        D        = alu_res[DATA_W-1:0];
        DEST_SEL = dst_p0;
        LOAD_EN  = is_write_op(op_p0);
        DONE     = 1'b1;
        state_d  = S_IDLE;
      end
      S_CLEAR: begin
        DEST_SEL = clr_cnt;
        LOAD_EN  = 1'b1;
        DONE     = (clr_cnt == 4'd15);
        if (clr_cnt == 4'd15) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (RST) begin
      state_d  = S_IDLE;
      IN_READY = 1'b0;
      A_SEL    = '0;
      B_SEL    = '0;
      D        = '0;
      DEST_SEL = '0;
      LOAD_EN  = 1'b0;
      DONE     = 1'b0;
    end
  end

  // Instruction latch (accept edge), operand capture (end of READ), clear counter.
  always_ff @(posedge C) begin
    if (RST) begin
      op_p0   <= '0;
      dst_p0  <= '0;
      srca_p0 <= '0;
      srcb_p0 <= '0;
      imm_p0  <= '0;
      opa_p1  <= '0;
      opb_p1  <= '0;
      clr_cnt <= '0;
    end else begin
      // p0: instruction fields captured on accept
      if (state_q == S_IDLE && IN_VALID) begin
        op_p0   <= OP;
        dst_p0  <= DST;
        srca_p0 <= SRCA;
        srcb_p0 <= SRCB;
        imm_p0  <= IMM;
      end
      // p1: register-file read data captured at the end of READ
      if (state_q == S_READ) begin
        opa_p1 <= A;
        opb_p1 <= B;
      end
      if (state_q == S_CLEAR) clr_cnt <= clr_cnt + 4'd1;
    end
  end

  // Flags: Z on every committed result, CY only from ADD/SUB, fixed after CLEAR.
  always_ff @(posedge C) begin
    if (RST) begin
      z_q  <= 1'b0;
      cy_q <= 1'b0;
    end else if (state_q == S_WRITE && is_write_op(op_p0)) begin
      z_q <= (alu_res[DATA_W-1:0] == '0);
      if (op_p0 == OP_ADD || op_p0 == OP_SUB) cy_q <= alu_res[DATA_W];
    end else if (state_q == S_CLEAR && clr_cnt == 4'd15) begin
      z_q  <= 1'b1;
      cy_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer with a behavioural 16x16 register file.
module tb_regfile_sequencer;

  logic        C, RST, IN_VALID, IN_READY;
  logic [3:0]  OP, DST, SRCA, SRCB;
  logic [15:0] IMM;
  logic [3:0]  A_SEL, B_SEL, DEST_SEL;
  logic [15:0] A, B, D;
  logic        LOAD_EN, DONE, Z, CY;

  logic [15:0] rf [16];

  int n_checks = 0;
  int n_errors = 0;

  regfile_sequencer dut (
    .C(C), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .OP(OP), .DST(DST), .SRCA(SRCA), .SRCB(SRCB), .IMM(IMM),
    .A_SEL(A_SEL), .B_SEL(B_SEL), .A(A), .B(B),
    .D(D), .DEST_SEL(DEST_SEL), .LOAD_EN(LOAD_EN), .DONE(DONE),
    .Z(Z), .CY(CY)
  );

  initial C = 1'b0;
  always #5 C = ~C;

  // Register file: combinational reads, write on rising edge.
  assign A = rf[A_SEL];
  assign B = rf[B_SEL];
  always @(posedge C) if (LOAD_EN) rf[DEST_SEL] <= D;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one READ/WRITE instruction; checks DONE lands two cycles after accept.
  task automatic run_instr(input logic [3:0] op, input logic [3:0] dst,
                           input logic [3:0] sa, input logic [3:0] sb,
                           input logic [15:0] imm, input logic exp_load,
                           input logic [15:0] exp_d);
    int n;
    n = 0;
    @(negedge C);
    while (!IN_READY && n < 20) begin
      @(negedge C);
      n++;
    end
    chk("ready_wait", 32'(IN_READY), 1);
    OP = op; DST = dst; SRCA = sa; SRCB = sb; IMM = imm; IN_VALID = 1'b1;
    @(posedge C);
    #1 IN_VALID = 1'b0;
    @(negedge C);
    chk("read_done", 32'(DONE), 0);
    chk("read_load", 32'(LOAD_EN), 0);
    chk("read_asel", 32'(A_SEL), 32'(sa));
    chk("read_bsel", 32'(B_SEL), 32'(sb));
    @(negedge C);
    chk("wr_done", 32'(DONE), 1);
    chk("wr_ready", 32'(IN_READY), 0);
    chk("wr_load", 32'(LOAD_EN), 32'(exp_load));
    if (exp_load) begin
      chk("wr_dest", 32'(DEST_SEL), 32'(dst));
      chk("wr_data", 32'(D), 32'(exp_d));
    end
    @(posedge C);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int nacc, nwr, last_acc;
    logic rdy;
    RST = 1'b1; IN_VALID = 1'b0; OP = '0; DST = '0; SRCA = '0; SRCB = '0; IMM = '0;
    repeat (2) @(posedge C);
    @(negedge C);
    chk("rst_ready", 32'(IN_READY), 0);
    chk("rst_load", 32'(LOAD_EN), 0);
    chk("rst_done", 32'(DONE), 0);
    @(posedge C);
    #1 RST = 1'b0;
    @(negedge C);
    chk("post_rst_ready", 32'(IN_READY), 1);
    chk("post_rst_z", 32'(Z), 0);
    chk("post_rst_cy", 32'(CY), 0);
    chk("post_rst_asel", 32'(A_SEL), 0);
    chk("post_rst_dsel", 32'(DEST_SEL), 0);
    chk("post_rst_d", 32'(D), 0);

    // ADD with carry out and zero result
    run_instr(4'd10, 4'd3, 4'd0, 4'd0, 16'hFFFF, 1'b1, 16'hFFFF);
    run_instr(4'd10, 4'd4, 4'd0, 4'd0, 16'h0001, 1'b1, 16'h0001);
    run_instr(4'd2,  4'd5, 4'd3, 4'd4, 16'h0000, 1'b1, 16'h0000);
    chk("add_r5", 32'(rf[5]), 0);
    chk("add_z", 32'(Z), 1);
    chk("add_cy", 32'(CY), 1);

    // SUB with borrow, then SHL keeps CY
    run_instr(4'd10, 4'd1, 4'd0, 4'd0, 16'h0003, 1'b1, 16'h0003);
    run_instr(4'd10, 4'd2, 4'd0, 4'd0, 16'h0005, 1'b1, 16'h0005);
    run_instr(4'd3,  4'd6, 4'd1, 4'd2, 16'h0000, 1'b1, 16'hFFFE);
    chk("sub_r6", 32'(rf[6]), 32'h0000FFFE);
    chk("sub_cy", 32'(CY), 1);
    chk("sub_z", 32'(Z), 0);
    run_instr(4'd8,  4'd7, 4'd6, 4'd1, 16'h0000, 1'b1, 16'hFFF0);
    chk("shl_r7", 32'(rf[7]), 32'h0000FFF0);
    chk("shl_cy", 32'(CY), 1);

    // Remaining ALU ops
    run_instr(4'd2,  4'd11, 4'd4, 4'd4, 16'h0000, 1'b1, 16'h0002);
    chk("add_nc_cy", 32'(CY), 0);
    run_instr(4'd9,  4'd12, 4'd3, 4'd1, 16'h0000, 1'b1, 16'h1FFF);
    run_instr(4'd6,  4'd13, 4'd3, 4'd3, 16'h0000, 1'b1, 16'h0000);
    chk("xor_z", 32'(Z), 1);
    run_instr(4'd7,  4'd14, 4'd4, 4'd0, 16'h0000, 1'b1, 16'hFFFE);
    chk("not_z", 32'(Z), 0);
    run_instr(4'd4,  4'd8,  4'd6, 4'd1, 16'h0000, 1'b1, 16'h0002);
    run_instr(4'd5,  4'd10, 4'd1, 4'd2, 16'h0000, 1'b1, 16'h0007);
    run_instr(4'd1,  4'd15, 4'd7, 4'd0, 16'h0000, 1'b1, 16'hFFF0);
    chk("mov_r15", 32'(rf[15]), 32'h0000FFF0);

    // Reserved opcode: no write, flags unchanged
    run_instr(4'd3,  4'd6, 4'd1, 4'd2, 16'h0000, 1'b1, 16'hFFFE);
    run_instr(4'd13, 4'd2, 4'd0, 4'd0, 16'h0000, 1'b0, 16'h0000);
    chk("rsv_r2", 32'(rf[2]), 5);
    chk("rsv_z", 32'(Z), 0);
    chk("rsv_cy", 32'(CY), 1);

    // Reset during the WRITE cycle of LDI r9
    run_instr(4'd10, 4'd9, 4'd0, 4'd0, 16'h0055, 1'b1, 16'h0055);
    @(negedge C);
    chk("rw_ready0", 32'(IN_READY), 1);
    OP = 4'd10; DST = 4'd9; IMM = 16'h1234; IN_VALID = 1'b1;
    @(posedge C);
    #1 IN_VALID = 1'b0;
    @(posedge C);
    #1 RST = 1'b1;
    @(negedge C);
    chk("rw_load", 32'(LOAD_EN), 0);
    chk("rw_done", 32'(DONE), 0);
    chk("rw_ready", 32'(IN_READY), 0);
    @(posedge C);
    #1 RST = 1'b0;
    @(negedge C);
    chk("rw_ready_after", 32'(IN_READY), 1);
    chk("rw_r9", 32'(rf[9]), 32'h55);
    chk("rw_cy", 32'(CY), 0);

    // CLR sweep after filling every register
    for (int i = 0; i < 16; i++)
      run_instr(4'd10, 4'(i), 4'd0, 4'd0, 16'h0100 + 16'(i), 1'b1, 16'h0100 + 16'(i));
    @(negedge C);
    OP = 4'd11; DST = 4'd0; IN_VALID = 1'b1;
    @(posedge C);
    #1 IN_VALID = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge C);
      chk("clr_dsel", 32'(DEST_SEL), 32'(k));
      chk("clr_load", 32'(LOAD_EN), 1);
      chk("clr_d", 32'(D), 0);
      chk("clr_done", 32'(DONE), (k == 15) ? 1 : 0);
      chk("clr_asel", 32'(A_SEL), 0);
    end
    @(posedge C);
    #1;
    for (int i = 0; i < 16; i++) chk("clr_reg", 32'(rf[i]), 0);
    chk("clr_z", 32'(Z), 1);
    chk("clr_cy", 32'(CY), 0);

    // Back-to-back MOV chain with IN_VALID held high
    run_instr(4'd10, 4'd1, 4'd0, 4'd0, 16'hAAAA, 1'b1, 16'hAAAA);
    OP = 4'd1; DST = 4'd2; SRCA = 4'd1; SRCB = 4'd0; IN_VALID = 1'b1;
    nacc = 0; nwr = 0; last_acc = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge C);
      rdy = IN_READY;
      if (LOAD_EN) nwr++;
      @(posedge C);
      #1;
      if (rdy && IN_VALID) begin
        if (nacc > 0) chk("b2b_spacing", 32'(cyc - last_acc), 3);
        last_acc = cyc;
        nacc++;
        if (nacc == 3) IN_VALID = 1'b0;
        else begin
          DST = DST + 4'd1;
          SRCA = SRCA + 4'd1;
        end
      end
    end
    chk("b2b_accepts", 32'(nacc), 3);
    chk("b2b_writes", 32'(nwr), 3);
    chk("b2b_r2", 32'(rf[2]), 32'hAAAA);
    chk("b2b_r3", 32'(rf[3]), 32'hAAAA);
    chk("b2b_r4", 32'(rf[4]), 32'hAAAA);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
